// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes an instruction/format pair and queues the
// XLEN-wide immediate, error flag and tag in a 2-entry skid FIFO with valid/ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [2:0] SEL_I  = 3'b000;
  localparam logic [2:0] SEL_IU = 3'b001;
  localparam logic [2:0] SEL_S  = 3'b010;
  localparam logic [2:0] SEL_B  = 3'b011;
  localparam logic [2:0] SEL_U  = 3'b100;
  localparam logic [2:0] SEL_SH = 3'b101;
  localparam logic [2:0] SEL_J  = 3'b110;

  entry_t            new_e;
  entry_t            head_q, head_d;
  entry_t            skid_q, skid_d;
  logic [1:0]        occ_q, occ_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              acc, xfer;
  logic [XLEN-1:0]   sx;
  logic signed [31:0] u_imm;
  logic              unused_opcode;

  // Opcode bits never feed any immediate format.
  assign unused_opcode = ^in_instr[6:0];

  assign sx    = {XLEN{in_instr[31]}};
  assign u_imm = {in_instr[31:12], 12'h000};

  always_comb begin
    new_e.imm = '0;
    new_e.err = 1'b0;
    new_e.tag = in_tag;
    case (in_sel)
      SEL_I:  new_e.imm = {sx[XLEN-1:12], in_instr[31:20]};
      SEL_IU: new_e.imm = {{(XLEN-12){1'b0}}, in_instr[31:20]};
      SEL_S:  new_e.imm = {sx[XLEN-1:12], in_instr[31:25], in_instr[11:7]};
      SEL_B:  new_e.imm = {sx[XLEN-1:13], in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
      SEL_U:  new_e.imm = XLEN'(u_imm);
      SEL_SH: begin
        if (XLEN == 64) new_e.imm[5:0] = in_instr[25:20];
        else            new_e.imm[4:0] = in_instr[24:20];
      end
      SEL_J:  new_e.imm = {sx[XLEN-1:21], in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
      default: new_e.err = 1'b1;
    endcase
  end

  assign acc  = in_valid & in_ready_q;
  assign xfer = out_valid_q & out_ready;

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    case ({acc, xfer})
      2'b10: begin
        if (occ_q == 2'd0) head_d = new_e;
        else               skid_d = new_e;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = skid_q;
        occ_d = occ_q - 2'd1;
      end
      // Accept with transfer is only reachable at occupancy 1 (in_ready is low at 2).
      2'b11: head_d = new_e;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      skid_q      <= '0;
      occ_q       <= 2'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      head_q      <= head_d;
      skid_q      <= skid_d;
      occ_q       <= occ_d;
      out_valid_q <= (occ_d != 2'd0);
      in_ready_q  <= (occ_d != 2'd2);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = head_q.imm;
  assign out_err   = head_q.err;
  assign out_tag   = head_q.tag;

endmodule
